// File: rtl/rx_filtered_samples_ctrl_pkg.sv
// Shared rx constants: sample/BRAM geometry and the read-sequencer state encoding.
package rx_filtered_samples_ctrl_pkg;
   localparam int RX_DW    = 16;
   localparam int RX_AW    = 9;
   localparam int RX_DEPTH = 2**RX_AW;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/rx_filtered_samples_ctrl_if.sv
// Sample input, correlator burst stream and BRAM ports of the filtered-sample sequencer.
interface rx_filtered_samples_ctrl_if
   import rx_filtered_samples_ctrl_pkg::*;
#(
   parameter int DW = RX_DW,
   parameter int AW = RX_AW
) ();
   logic          sample_valid;
   logic [DW-1:0] sample_in;
   logic          burst_req;
   logic          burst_ack;
   logic          burst_nack;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_last;
   logic          busy;
   logic          overrun;
   logic [AW:0]   fill_level;
   logic          bram_ena;
   logic          bram_wea;
   logic [AW-1:0] bram_addra;
   logic [DW-1:0] bram_dia;
   logic          bram_enb;
   logic [AW-1:0] bram_addrb;
   logic [DW-1:0] bram_dob;

   modport master (
      input  sample_valid, sample_in, burst_req, bram_dob,
      output burst_ack, burst_nack, rd_data, rd_valid, rd_last, busy, overrun,
             fill_level, bram_ena, bram_wea, bram_addra, bram_dia, bram_enb, bram_addrb
   );

   modport slave (
      output sample_valid, sample_in, burst_req, bram_dob,
      input  burst_ack, burst_nack, rd_data, rd_valid, rd_last, busy, overrun,
             fill_level, bram_ena, bram_wea, bram_addra, bram_dia, bram_enb, bram_addrb
   );
endinterface

// File: rtl/rx_filtered_samples_ctrl_wr_ptr.sv
// Circular write pointer, saturating fill level and writes-since-acceptance counter.
module rx_circ_wr_ptr
   import rx_filtered_samples_ctrl_pkg::*;
#(
   parameter int AW = RX_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr,
   input  logic          i_cnt_clr,
   output logic [AW-1:0] o_wr_ptr,
   output logic [AW:0]   o_fill_level,
   output logic [AW:0]   o_wr_cnt
);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(2**AW);

   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_fill;
   logic [AW:0]   r_wr_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_fill   <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (i_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_fill != DEPTH_W) r_fill <= r_fill + (AW+1)'(1);
         end
         // The write landing in the acceptance cycle is not counted.
         if (i_cnt_clr)
            r_wr_cnt <= '0;
         else if (i_wr && r_wr_cnt != DEPTH_W)
            r_wr_cnt <= r_wr_cnt + (AW+1)'(1);
      end
   end

   assign o_wr_ptr     = r_wr_ptr;
   assign o_fill_level = r_fill;
   assign o_wr_cnt     = r_wr_cnt;
endmodule

// File: rtl/rx_filtered_samples_ctrl.sv
// Filtered-sample BRAM sequencer: circular write of the filter stream and
// oldest-first read-back of the newest WINDOW samples on correlator request.
module rx_filtered_samples_ctrl
   import rx_filtered_samples_ctrl_pkg::*;
#(
   parameter int DW     = RX_DW,
   parameter int AW     = RX_AW,
   parameter int WINDOW = 256
) (
   input  logic                        clk,
   input  logic                        rx_rst_n,
   rx_filtered_samples_ctrl_if.master  io_bus
);
   localparam int          DEPTH    = 2**AW;
   localparam logic [AW:0] WIN_W    = (AW+1)'(WINDOW);
   localparam logic [AW-1:0] WIN_MOD = AW'(WINDOW % DEPTH);
   localparam logic [AW:0] OVR_BASE = (AW+1)'(DEPTH - WINDOW);

   logic [AW-1:0] w_wr_ptr;
   logic [AW:0]   w_fill;
   logic [AW:0]   w_wr_cnt;
   logic          w_accept;
   logic          w_issue;
   logic          w_last_issue;
   logic          w_ovr_hit;

   logic [1:0]    r_state;
   logic [AW:0]   r_k;
   logic [AW-1:0] r_rd_addr;
   logic          r_ack;
   logic          r_nack;
   logic          r_enb_d;
   logic          r_last_d;
   logic          r_overrun;

   rx_circ_wr_ptr #(.AW(AW)) u_wr_ptr (
      .clk          (clk),
      .rst_n        (rx_rst_n),
      .i_wr         (io_bus.sample_valid),
      .i_cnt_clr    (w_accept),
      .o_wr_ptr     (w_wr_ptr),
      .o_fill_level (w_fill),
      .o_wr_cnt     (w_wr_cnt)
   );

   assign w_accept     = (r_state == ST_IDLE) && io_bus.burst_req && (w_fill >= WIN_W);
   assign w_issue      = (r_state == ST_READ);
   assign w_last_issue = w_issue && (r_k == WIN_W - (AW+1)'(1));
   // A write counted as wr_cnt+1 lands on read slot wr_cnt+1-(DEPTH-WINDOW)-1;
   // it is destructive when that slot is the current issue or a later one.
   assign w_ovr_hit    = w_issue && io_bus.sample_valid && (w_wr_cnt >= OVR_BASE + r_k);

   always_ff @(posedge clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         r_state   <= ST_IDLE;
         r_k       <= '0;
         r_rd_addr <= '0;
         r_ack     <= 1'b0;
         r_nack    <= 1'b0;
         r_enb_d   <= 1'b0;
         r_last_d  <= 1'b0;
      end else begin
         r_ack    <= 1'b0;
         r_nack   <= 1'b0;
         r_enb_d  <= w_issue;
         r_last_d <= w_last_issue;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ack     <= 1'b1;
                  r_state   <= ST_READ;
                  r_k       <= '0;
                  r_rd_addr <= w_wr_ptr - WIN_MOD;
               end else if (io_bus.burst_req) begin
                  r_nack <= 1'b1;
               end
            end
            ST_READ: begin
               r_k       <= r_k + (AW+1)'(1);
               r_rd_addr <= r_rd_addr + AW'(1);
               if (w_last_issue) r_state <= ST_DRAIN;
            end
            ST_DRAIN: r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rx_rst_n) begin
      if (!rx_rst_n)
         r_overrun <= 1'b0;
      else if (w_accept)
         r_overrun <= 1'b0;
      else if (w_ovr_hit)
         r_overrun <= 1'b1;
   end

   assign io_bus.bram_ena   = io_bus.sample_valid;
   assign io_bus.bram_wea   = io_bus.sample_valid;
   assign io_bus.bram_addra = w_wr_ptr;
   assign io_bus.bram_dia   = io_bus.sample_in;
   assign io_bus.bram_enb   = w_issue;
   assign io_bus.bram_addrb = r_rd_addr;
   assign io_bus.rd_data    = io_bus.bram_dob;
   assign io_bus.rd_valid   = r_enb_d;
   assign io_bus.rd_last    = r_last_d;
   assign io_bus.busy       = (r_state != ST_IDLE);
   assign io_bus.overrun    = r_overrun;
   assign io_bus.fill_level = w_fill;
   assign io_bus.burst_ack  = r_ack;
   assign io_bus.burst_nack = r_nack;
endmodule

// File: tb/tb_rx_filtered_samples_ctrl.sv
// Scoreboard bench: a WINDOW=256 instance checked sample by sample, plus a
// WINDOW=512 instance sharing the sample stream for the full-buffer overrun case.
module tb_rx_filtered_samples_ctrl;
   typedef struct {
      logic [15:0] d;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rx_rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic [15:0] s_data = '0;
   logic        req = 1'b0;
   logic        req512 = 1'b0;
   int          sidx = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n512_rd = 0;
   int          n512_last = 0;
   exp_t        exp_q[$];
   int          exp_a[$];
   exp_t        mon_e;
   int          mon_a;
   logic [15:0] mem    [512];
   logic [15:0] mem512 [512];

   always #5 clk = ~clk;

   rx_filtered_samples_ctrl_if #(.DW(16), .AW(9)) bus ();
   rx_filtered_samples_ctrl_if #(.DW(16), .AW(9)) bus5 ();

   assign bus.sample_valid  = s_valid;
   assign bus.sample_in     = s_data;
   assign bus.burst_req     = req;
   assign bus5.sample_valid = s_valid;
   assign bus5.sample_in    = s_data;
   assign bus5.burst_req    = req512;

   rx_filtered_samples_ctrl #(.DW(16), .AW(9), .WINDOW(256)) u_dut (
      .clk      (clk),
      .rx_rst_n (rx_rst_n),
      .io_bus   (bus)
   );

   rx_filtered_samples_ctrl #(.DW(16), .AW(9), .WINDOW(512)) u_dut512 (
      .clk      (clk),
      .rx_rst_n (rx_rst_n),
      .io_bus   (bus5)
   );

   // Read-first BRAM models with registered output.
   always @(posedge clk) begin
      if (bus.bram_enb) bus.bram_dob <= mem[bus.bram_addrb];
      if (bus.bram_ena && bus.bram_wea) mem[bus.bram_addra] <= bus.bram_dia;
   end

   always @(posedge clk) begin
      if (bus5.bram_enb) bus5.bram_dob <= mem512[bus5.bram_addrb];
      if (bus5.bram_ena && bus5.bram_wea) mem512[bus5.bram_addra] <= bus5.bram_dia;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected stream whenever the DUT presents a read or a sample.
   always @(negedge clk) begin
      if (rx_rst_n) begin
         if (bus.bram_enb) begin
            if (exp_a.size() == 0) chk("enb_unexpected", int'(bus.bram_enb), 0);
            else begin
               mon_a = exp_a.pop_front();
               chk("addrb", int'(bus.bram_addrb), mon_a);
            end
         end
         if (bus.rd_valid) begin
            if (exp_q.size() == 0) chk("rd_valid_unexpected", int'(bus.rd_valid), 0);
            else begin
               mon_e = exp_q.pop_front();
               chk("rd_data", int'(bus.rd_data), int'(mon_e.d));
               chk("rd_last", int'(bus.rd_last), int'(mon_e.last));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rx_rst_n && bus5.rd_valid) begin
         n512_rd++;
         if (bus5.rd_last) n512_last++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = 16'(sidx);
         sidx++;
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic push_exp(input int first);
      for (int k = 0; k < 256; k++) begin
         exp_q.push_back('{d: 16'(first + k), last: (k == 255)});
         exp_a.push_back((first + k) % 512);
      end
   endtask

   // Request on the 256 instance; when stream=1 a sample is also written in the request cycle.
   task automatic req256(input bit exp_ack, input int first, input bit stream, input bit hold);
      s_valid = stream;
      s_data  = 16'(sidx);
      if (stream) sidx++;
      req = 1'b1;
      if (exp_ack) push_exp(first);
      tick();
      if (!hold) req = 1'b0;
      chk("burst_ack", int'(bus.burst_ack), int'(exp_ack));
      chk("burst_nack", int'(bus.burst_nack), int'(!exp_ack));
   endtask

   task automatic busy_len(input int exp);
      int n = 0;
      while (bus.busy && n < 700) begin
         n++;
         tick();
      end
      chk("busy_len", n, exp);
   endtask

   task automatic do_reset();
      rx_rst_n = 1'b0;
      s_valid  = 1'b0;
      req      = 1'b0;
      req512   = 1'b0;
      tick();
      tick();
      exp_q.delete();
      exp_a.delete();
      sidx     = 0;
      rx_rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int last_c;
      int ack_c;

      // Reset state
      rx_rst_n = 1'b0;
      tick();
      tick();
      chk("rst_ack", int'(bus.burst_ack), 0);
      chk("rst_nack", int'(bus.burst_nack), 0);
      chk("rst_rd_valid", int'(bus.rd_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_overrun", int'(bus.overrun), 0);
      chk("rst_fill", int'(bus.fill_level), 0);
      chk("rst_enb", int'(bus.bram_enb), 0);
      do_reset();

      // 1: underfilled request is refused
      feed(100);
      chk("t1_fill", int'(bus.fill_level), 100);
      req256(1'b0, 0, 1'b0, 1'b0);
      tick();
      chk("t1_nack_pulse", int'(bus.burst_nack), 0);
      chk("t1_busy", int'(bus.busy), 0);

      // 2: 300 samples -> burst 44..299
      do_reset();
      feed(300);
      req256(1'b1, 44, 1'b0, 1'b0);
      busy_len(257);
      chk("t2_fill", int'(bus.fill_level), 300);
      chk("t2_left", exp_q.size(), 0);

      // 3: 600 samples -> start 344, addrb wraps, fill saturated
      do_reset();
      feed(600);
      chk("t3_fill", int'(bus.fill_level), 512);
      req256(1'b1, 344, 1'b0, 1'b0);
      busy_len(257);
      chk("t3_fill_after", int'(bus.fill_level), 512);
      chk("t3_left", exp_q.size(), 0);

      // 4a: continuous writes during a 256 burst do not overrun
      do_reset();
      feed(300);
      req256(1'b1, sidx - 256, 1'b1, 1'b0);
      feed(270);
      chk("t4_overrun256", int'(bus.overrun), 0);
      chk("t4_left", exp_q.size(), 0);

      // 4b: continuous writes during a 512 burst overrun; cleared by the next ack
      do_reset();
      feed(600);
      n512_rd   = 0;
      n512_last = 0;
      s_valid = 1'b1; s_data = 16'(sidx); sidx++; req512 = 1'b1;
      tick();
      req512 = 1'b0;
      chk("t4_ack512", int'(bus5.burst_ack), 1);
      feed(530);
      chk("t4_rd512_count", n512_rd, 512);
      chk("t4_last512_count", n512_last, 1);
      chk("t4_overrun512", int'(bus5.overrun), 1);
      chk("t4_busy512", int'(bus5.busy), 0);
      s_valid = 1'b1; s_data = 16'(sidx); sidx++; req512 = 1'b1;
      tick();
      req512 = 1'b0;
      chk("t4_ack512_2", int'(bus5.burst_ack), 1);
      chk("t4_overrun512_clr", int'(bus5.overrun), 0);
      feed(520);

      // 5: reset at k=10 aborts at once and discards the buffer
      do_reset();
      feed(300);
      req256(1'b1, 44, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      #1 rx_rst_n = 1'b0;
      #1;
      chk("t5_rd_valid", int'(bus.rd_valid), 0);
      chk("t5_busy", int'(bus.busy), 0);
      chk("t5_enb", int'(bus.bram_enb), 0);
      exp_q.delete();
      exp_a.delete();
      tick();
      rx_rst_n = 1'b1;
      sidx = 0;
      tick();
      chk("t5_fill", int'(bus.fill_level), 0);
      req256(1'b0, 0, 1'b0, 1'b0);

      // 6: held request -> back-to-back bursts, one idle cycle between
      do_reset();
      feed(300);
      req256(1'b1, 44, 1'b0, 1'b1);
      push_exp(44);
      last_c = -100;
      ack_c  = -1;
      for (int c = 0; c < 700; c++) begin
         if (bus.rd_last) last_c = c;
         if (c > 0 && bus.burst_ack) begin
            ack_c = c;
            req = 1'b0;
            break;
         end
         tick();
      end
      chk("t6_gap", ack_c - last_c, 2);
      tick();
      busy_len(256);
      chk("t6_left", exp_q.size(), 0);

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
